// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle CPU: FSM states, opcodes and
// instruction field positions.
package cpu_mc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07,
    OP_LWD   = 8'h08,
    OP_LWI   = 8'h09,
    OP_SWD   = 8'h0A,
    OP_SWI   = 8'h0B,
    OP_SLL   = 8'h0C,
    OP_SRL   = 8'h0D,
    OP_SRA   = 8'h0E,
    OP_ROR   = 8'h0F,
    OP_BNE   = 8'h10
  } opcode_e;

  // Bit positions of the four byte-wide instruction fields.
  localparam int FIELD_W = 8;
  localparam int OPC_LSB = 24;
  localparam int DST_LSB = 16;
  localparam int RT_LSB  = 8;
  localparam int RS_LSB  = 0;

  function automatic int reg_idx_w(input int reg_cnt);
    return (reg_cnt > 1) ? $clog2(reg_cnt) : 1;
  endfunction

  function automatic logic op_is_mem(input logic [7:0] op);
    return (op == OP_LWD) || (op == OP_LWI) || (op == OP_SWD) || (op == OP_SWI);
  endfunction

  function automatic logic op_is_load(input logic [7:0] op);
    return (op == OP_LWD) || (op == OP_LWI);
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// all registers cleared by the asynchronous active-low reset.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 8,
  localparam int IDX_W   = reg_idx_w(REG_CNT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU core: FETCH -> EXEC -> (MEM) -> FETCH, with a TRAP state
// entered on any undefined opcode.
module multicycle_cpu
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       INSTR_ADDR,
  output logic              INSTR_READ,
  input  logic [31:0]       INSTR_DATA,
  input  logic              INSTR_BUSYWAIT,
  output logic [DATA_W-1:0] DATA_ADDR,
  output logic [DATA_W-1:0] DATA_WDATA,
  output logic              DATA_READ,
  output logic              DATA_WRITE,
  input  logic [DATA_W-1:0] DATA_RDATA,
  input  logic              DATA_BUSYWAIT,
  output logic              TRAP
);

  localparam int IDX_W = reg_idx_w(REG_CNT);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic [7:0]        opcode, off8, imm8;
  logic [IDX_W-1:0]  dest_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0] rt_val, rs_val, alu_res, wr_data;
  logic              wr_en, op_legal, op_mem, op_load, op_writes, br_taken;
  logic [31:0]       pc_plus4, br_target;
  logic [31:0]       shamt, rot_amt;
  logic [2*DATA_W-1:0]      rot_full;
  logic signed [DATA_W-1:0] sra_res;
  logic              unused_rt_hi;

  // Instruction field decode
  assign opcode   = ir_q[OPC_LSB +: FIELD_W];
  assign off8     = ir_q[DST_LSB +: FIELD_W];
  assign imm8     = ir_q[RS_LSB  +: FIELD_W];
  assign dest_idx = ir_q[DST_LSB +: IDX_W];
  assign rt_idx   = ir_q[RT_LSB  +: IDX_W];
  assign rs_idx   = ir_q[RS_LSB  +: IDX_W];
  assign unused_rt_hi = ^ir_q[RT_LSB +: FIELD_W];

  assign op_legal  = (opcode <= OP_BNE);
  assign op_mem    = op_is_mem(opcode);
  assign op_load   = op_is_load(opcode);
  assign op_writes = opcode inside {OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                    OP_SLL, OP_SRL, OP_SRA, OP_ROR};
  assign br_taken  = (opcode == OP_J)
                   || ((opcode == OP_BEQ) && (rt_val == rs_val))
                   || ((opcode == OP_BNE) && (rt_val != rs_val));

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{off8[7]}}, off8, 2'b00};

  cpu_mc_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .we_i      (wr_en),
    .waddr_i   (dest_idx),
    .wdata_i   (wr_data),
    .raddr_a_i (rt_idx),
    .rdata_a_o (rt_val),
    .raddr_b_i (rs_idx),
    .rdata_b_o (rs_val)
  );

  // Arithmetic shift kept in its own signed context so it really sign-fills.
  assign shamt    = 32'(imm8);
  assign rot_amt  = shamt % 32'(DATA_W);
  assign rot_full = {rt_val, rt_val} >> rot_amt;
  assign sra_res  = $signed(rt_val) >>> shamt;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_LOADI: alu_res = DATA_W'(imm8);
      OP_MOV:   alu_res = rs_val;
      OP_ADD:   alu_res = rt_val + rs_val;
      OP_SUB:   alu_res = rt_val - rs_val;
      OP_AND:   alu_res = rt_val & rs_val;
      OP_OR:    alu_res = rt_val | rs_val;
      OP_SLL:   alu_res = (shamt >= 32'(DATA_W)) ? '0 : (rt_val << shamt);
      OP_SRL:   alu_res = (shamt >= 32'(DATA_W)) ? '0 : (rt_val >> shamt);
      OP_SRA:   alu_res = $unsigned(sra_res);
      OP_ROR:   alu_res = rot_full[DATA_W-1:0];
      default:  alu_res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (!INSTR_BUSYWAIT) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!op_legal)   state_d = ST_TRAP;
        else if (op_mem) state_d = ST_MEM;
        else             state_d = ST_FETCH;
      end
      ST_MEM:   if (!DATA_BUSYWAIT) state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_FETCH;
    endcase
  end

  // FSM: outputs and register-file write strobe
  always_comb begin
    INSTR_READ = 1'b0;
    DATA_READ  = 1'b0;
    DATA_WRITE = 1'b0;
    TRAP       = 1'b0;
    wr_en      = 1'b0;
    wr_data    = alu_res;
    case (state_q)
      ST_FETCH: INSTR_READ = 1'b1;
      ST_EXEC:  wr_en = op_writes;
      ST_MEM: begin
        DATA_READ  = op_load;
        DATA_WRITE = !op_load;
        if (op_load && !DATA_BUSYWAIT) begin
          wr_en   = 1'b1;
          wr_data = DATA_RDATA;
        end
      end
      ST_TRAP:  TRAP = 1'b1;
      default:  ;
    endcase
  end

  // Datapath registers: memory address/data are captured in EXEC so they stay
  // stable for however long the data memory stalls.
  always_comb begin
    ir_d     = ir_q;
    pc_d     = pc_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      ST_FETCH: if (!INSTR_BUSYWAIT) ir_d = INSTR_DATA;
      ST_EXEC: begin
        maddr_d  = ((opcode == OP_LWD) || (opcode == OP_SWD)) ? rs_val : DATA_W'(imm8);
        mwdata_d = rt_val;
        if (op_legal && !op_mem) pc_d = br_taken ? br_target : pc_plus4;
      end
      ST_MEM:   if (!DATA_BUSYWAIT) pc_d = pc_plus4;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q     <= '0;
      ir_q     <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign INSTR_ADDR = pc_q;
  assign DATA_ADDR  = maddr_q;
  assign DATA_WDATA = mwdata_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs in a behavioural
// instruction/data memory, results observed on the store bus and PC.
module tb_multicycle_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_READ;
  logic [31:0] INSTR_DATA;
  logic        INSTR_BUSYWAIT = 1'b0;
  logic [7:0]  DATA_ADDR;
  logic [7:0]  DATA_WDATA;
  logic        DATA_READ;
  logic        DATA_WRITE;
  logic [7:0]  DATA_RDATA;
  logic        DATA_BUSYWAIT = 1'b0;
  logic        TRAP;

  logic [31:0] imem [64];
  logic [7:0]  dmem [256];
  int          checks = 0;
  int          errors = 0;
  int          st_count = 0;

  multicycle_cpu #(.DATA_W(8), .REG_CNT(8)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR_ADDR     (INSTR_ADDR),
    .INSTR_READ     (INSTR_READ),
    .INSTR_DATA     (INSTR_DATA),
    .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
    .DATA_ADDR      (DATA_ADDR),
    .DATA_WDATA     (DATA_WDATA),
    .DATA_READ      (DATA_READ),
    .DATA_WRITE     (DATA_WRITE),
    .DATA_RDATA     (DATA_RDATA),
    .DATA_BUSYWAIT  (DATA_BUSYWAIT),
    .TRAP           (TRAP)
  );

  always #5 CLK = ~CLK;

  assign INSTR_DATA = imem[INSTR_ADDR[7:2]];
  assign DATA_RDATA = dmem[DATA_ADDR];

  always @(posedge CLK) begin
    if (DATA_WRITE && !DATA_BUSYWAIT) begin
      dmem[DATA_ADDR] <= DATA_WDATA;
      st_count <= st_count + 1;
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] t, input logic [7:0] s);
    return {op, d, t, s};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic reset_cpu();
    RESET = 1'b0;
    INSTR_BUSYWAIT = 1'b0;
    DATA_BUSYWAIT = 1'b0;
    #1;
    chk("rst_pc", INSTR_ADDR, 32'd0);
    chk("rst_trap", 32'(TRAP), 32'd0);
    chk("rst_dread", 32'(DATA_READ), 32'd0);
    chk("rst_dwrite", 32'(DATA_WRITE), 32'd0);
    tick();
    RESET = 1'b1;
    #1;
    chk("rst_iread", 32'(INSTR_READ), 32'd1);
  endtask

  // Wait (bounded) for the next store request, check it, then let it commit.
  task automatic expect_store(input string tag, input logic [7:0] addr, input logic [7:0] data);
    logic seen;
    int   n0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (DATA_WRITE) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      $display("store %s addr=%h data=%h", tag, DATA_ADDR, DATA_WDATA);
      chk({tag, "_addr"}, 32'(DATA_ADDR), 32'(addr));
      chk({tag, "_wdata"}, 32'(DATA_WDATA), 32'(data));
      chk({tag, "_rd_low"}, 32'(DATA_READ), 32'd0);
      n0 = st_count;
      tick();
      chk({tag, "_commit"}, st_count, n0 + 1);
    end
  endtask

  initial begin
    int n0;

    // Program 1: ALU ops, fetch stall, LOADI/SUB latency
    clear_imem();
    imem[0]  = ins(8'h00, 8'h01, 8'h00, 8'h05);
    imem[1]  = ins(8'h00, 8'h02, 8'h00, 8'h03);
    imem[2]  = ins(8'h03, 8'h03, 8'h01, 8'h02);
    imem[3]  = ins(8'h0B, 8'h00, 8'h03, 8'h20);
    imem[4]  = ins(8'h02, 8'h04, 8'h02, 8'h01);
    imem[5]  = ins(8'h04, 8'h05, 8'h01, 8'h02);
    imem[6]  = ins(8'h05, 8'h06, 8'h01, 8'h02);
    imem[7]  = ins(8'h03, 8'h07, 8'h02, 8'h01);
    imem[8]  = ins(8'h01, 8'h00, 8'h00, 8'h07);
    imem[9]  = ins(8'h0B, 8'h00, 8'h04, 8'h21);
    imem[10] = ins(8'h0B, 8'h00, 8'h05, 8'h22);
    imem[11] = ins(8'h0B, 8'h00, 8'h06, 8'h23);
    imem[12] = ins(8'h0B, 8'h00, 8'h00, 8'h24);
    tick();
    reset_cpu();
    INSTR_BUSYWAIT = 1'b1;
    tick();
    tick();
    chk("ifetch_stall_read", 32'(INSTR_READ), 32'd1);
    chk("ifetch_stall_pc", INSTR_ADDR, 32'd0);
    INSTR_BUSYWAIT = 1'b0;
    repeat (6) tick();
    chk("sub_pc_after_6", INSTR_ADDR, 32'd12);
    expect_store("sub_r3", 8'h20, 8'h02);
    expect_store("add_r4", 8'h21, 8'h08);
    expect_store("and_r5", 8'h22, 8'h01);
    expect_store("or_r6", 8'h23, 8'h07);
    expect_store("sub_wrap_mov_r0", 8'h24, 8'hFE);
    chk("prog1_end_pc", INSTR_ADDR, 32'd52);

    // Program 2: shifts and rotates on 0x81
    clear_imem();
    imem[0]  = ins(8'h00, 8'h01, 8'h00, 8'h81);
    imem[1]  = ins(8'h0E, 8'h02, 8'h01, 8'h09);
    imem[2]  = ins(8'h0F, 8'h03, 8'h01, 8'h09);
    imem[3]  = ins(8'h0C, 8'h04, 8'h01, 8'h08);
    imem[4]  = ins(8'h0D, 8'h05, 8'h01, 8'h03);
    imem[5]  = ins(8'h0E, 8'h06, 8'h01, 8'h02);
    imem[6]  = ins(8'h0C, 8'h07, 8'h01, 8'h01);
    imem[7]  = ins(8'h0F, 8'h00, 8'h01, 8'h0C);
    imem[8]  = ins(8'h0B, 8'h00, 8'h02, 8'h30);
    imem[9]  = ins(8'h0B, 8'h00, 8'h03, 8'h31);
    imem[10] = ins(8'h0B, 8'h00, 8'h04, 8'h32);
    imem[11] = ins(8'h0B, 8'h00, 8'h05, 8'h33);
    imem[12] = ins(8'h0B, 8'h00, 8'h06, 8'h34);
    imem[13] = ins(8'h0B, 8'h00, 8'h07, 8'h35);
    imem[14] = ins(8'h0B, 8'h00, 8'h00, 8'h36);
    imem[15] = ins(8'h0D, 8'h01, 8'h01, 8'hC8);
    imem[16] = ins(8'h0B, 8'h00, 8'h01, 8'h37);
    reset_cpu();
    expect_store("sra9", 8'h30, 8'hFF);
    expect_store("ror9", 8'h31, 8'hC0);
    expect_store("sll8", 8'h32, 8'h00);
    expect_store("srl3", 8'h33, 8'h10);
    expect_store("sra2", 8'h34, 8'hE0);
    expect_store("sll1", 8'h35, 8'h02);
    expect_store("ror12", 8'h36, 8'h18);
    expect_store("srl200", 8'h37, 8'h00);

    // Program 3: stores, a stalled load, register-indirect load/store
    clear_imem();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h5A);
    imem[1] = ins(8'h0B, 8'h00, 8'h01, 8'h10);
    imem[2] = ins(8'h09, 8'h02, 8'h00, 8'h10);
    imem[3] = ins(8'h0B, 8'h00, 8'h02, 8'h11);
    imem[4] = ins(8'h00, 8'h05, 8'h00, 8'h40);
    imem[5] = ins(8'h00, 8'h03, 8'h00, 8'h11);
    imem[6] = ins(8'h08, 8'h04, 8'h00, 8'h03);
    imem[7] = ins(8'h02, 8'h06, 8'h04, 8'h04);
    imem[8] = ins(8'h0A, 8'h00, 8'h06, 8'h05);
    reset_cpu();
    expect_store("swi_r1", 8'h10, 8'h5A);
    DATA_BUSYWAIT = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lwi_hold%0d_read", k), 32'(DATA_READ), 32'd1);
      chk($sformatf("lwi_hold%0d_write", k), 32'(DATA_WRITE), 32'd0);
      chk($sformatf("lwi_hold%0d_addr", k), 32'(DATA_ADDR), 32'h10);
      if (k < 4) tick();
    end
    chk("lwi_pc_before_done", INSTR_ADDR, 32'd8);
    DATA_BUSYWAIT = 1'b0;
    tick();
    $display("load lwi addr=10 done at edge 7 pc=%h", INSTR_ADDR);
    chk("lwi_pc_after_7", INSTR_ADDR, 32'd12);
    chk("lwi_read_dropped", 32'(DATA_READ), 32'd0);
    expect_store("lwi_r2", 8'h11, 8'h5A);
    expect_store("lwd_add_swd", 8'h40, 8'hB4);

    // Program 4: branches and jump
    clear_imem();
    imem[0]  = ins(8'h00, 8'h01, 8'h00, 8'h07);
    imem[1]  = ins(8'h00, 8'h02, 8'h00, 8'h07);
    imem[2]  = ins(8'h07, 8'hFE, 8'h01, 8'h02);
    imem[3]  = ins(8'h10, 8'h02, 8'h01, 8'h03);
    imem[6]  = ins(8'h06, 8'h01, 8'h00, 8'h00);
    imem[8]  = ins(8'h07, 8'h05, 8'h01, 8'h03);
    imem[9]  = ins(8'h03, 8'h04, 8'h03, 8'h01);
    imem[10] = ins(8'h0B, 8'h00, 8'h04, 8'h50);
    reset_cpu();
    repeat (6) tick();
    chk("beq_taken_back", INSTR_ADDR, 32'd4);
    imem[2] = ins(8'h10, 8'hFE, 8'h01, 8'h02);
    repeat (2) tick();
    chk("loop_loadi_pc", INSTR_ADDR, 32'd8);
    repeat (2) tick();
    chk("bne_not_taken", INSTR_ADDR, 32'd12);
    repeat (2) tick();
    chk("bne_taken_fwd", INSTR_ADDR, 32'd24);
    repeat (2) tick();
    chk("j_fwd", INSTR_ADDR, 32'd32);
    repeat (2) tick();
    chk("beq_not_taken", INSTR_ADDR, 32'd36);
    expect_store("sub_neg", 8'h50, 8'hF9);

    // Program 5: illegal opcode, then reset in the middle of a stalled store
    clear_imem();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h09);
    imem[1] = ins(8'h3F, 8'h00, 8'h00, 8'h00);
    reset_cpu();
    repeat (4) tick();
    chk("trap_flag", 32'(TRAP), 32'd1);
    chk("trap_pc", INSTR_ADDR, 32'd4);
    chk("trap_iread", 32'(INSTR_READ), 32'd0);
    repeat (3) tick();
    chk("trap_hold_flag", 32'(TRAP), 32'd1);
    chk("trap_hold_pc", INSTR_ADDR, 32'd4);
    chk("trap_hold_dreq", 32'({DATA_READ, DATA_WRITE}), 32'd0);

    imem[1] = ins(8'h0B, 8'h00, 8'h01, 8'h60);
    imem[2] = ins(8'h0B, 8'h00, 8'h02, 8'h61);
    reset_cpu();
    chk("trap_cleared", 32'(TRAP), 32'd0);
    DATA_BUSYWAIT = 1'b1;
    repeat (4) tick();
    chk("midmem_write", 32'(DATA_WRITE), 32'd1);
    chk("midmem_pc", INSTR_ADDR, 32'd4);
    n0 = st_count;
    tick();
    RESET = 1'b0;
    #1;
    chk("abort_pc", INSTR_ADDR, 32'd0);
    chk("abort_write", 32'(DATA_WRITE), 32'd0);
    chk("abort_iread", 32'(INSTR_READ), 32'd1);
    DATA_BUSYWAIT = 1'b0;
    tick();
    chk("abort_no_store", st_count, n0);
    reset_cpu();
    expect_store("rerun_r1", 8'h60, 8'h09);
    expect_store("rerun_r2_zero", 8'h61, 8'h00);
    imem[3] = ins(8'h11, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("trap_op11", 32'(TRAP), 32'd1);
    chk("trap_op11_pc", INSTR_ADDR, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
